// File: rtl/dac5571_wave_seq_pkg.sv
// Shared definitions for the DAC5571 sample sequencer: waveform codes, FSM states, tick divider helper.
package dac5571_wave_seq_pkg;

  localparam int VOL_W = 8;

  localparam logic [1:0] WAVE_DC  = 2'd0;
  localparam logic [1:0] WAVE_SAW = 2'd1;
  localparam logic [1:0] WAVE_TRI = 2'd2;
  localparam logic [1:0] WAVE_SQR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_TRIG = 2'd2,
    ST_WAIT = 2'd3
  } seq_state_e;

  function automatic int tick_div(input int clk_hz, input int rate_hz);
    return clk_hz / rate_hz;
  endfunction

endpackage

// File: rtl/dac5571_wave_seq_if.sv
// Write handshake between the sequencer (master) and the DAC5571 voltage-set stage (slave).
// set_trig is a 1-cycle request; vol is held stable from set_trig until the 1-cycle set_done pulse.
interface dac5571_wave_seq_if
  import dac5571_wave_seq_pkg::*;
();
  logic [VOL_W-1:0] vol;
  logic             set_trig;
  logic             set_done;

  modport master (output vol, output set_trig, input set_done);
  modport slave  (input vol, input set_trig, output set_done);
endinterface

// File: rtl/dac5571_wave_seq_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks, counting whenever reset is low.
module dac_tick_gen #(
  parameter int DIV = 50_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/dac5571_wave_seq.sv
// Sample sequencer feeding the DAC5571 voltage-set stage with DC/saw/triangle/square codes.
// Define DAC_WATCHDOG_EN to build the set_done watchdog (TIMEOUT_CYC) and its sticky err flag.
module dac5571_wave_seq
  import dac5571_wave_seq_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 50_000_000,
  parameter int UPDATE_RATE  = 1_000
`ifdef DAC_WATCHDOG_EN
  ,
  parameter int TIMEOUT_CYC  = 500_000
`endif
) (
  input  logic               sclk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         wave_sel,
  input  logic [VOL_W-1:0]   amp_lo,
  input  logic [VOL_W-1:0]   amp_hi,
  input  logic [VOL_W-1:0]   step,
  dac5571_wave_seq_if.master dac,
  output logic               busy,
  output logic               overrun,
  output logic               err,
  output seq_state_e         state_dbg
);
  localparam int TICK_DIV = tick_div(SYS_CLK_FREQ, UPDATE_RATE);

  logic             tick;
  logic             timeout;
  seq_state_e       state, state_n;
  logic [VOL_W-1:0] acc, acc_n;
  logic             dir_dn, dir_dn_n;
  logic             sq_ph, sq_ph_n;
  logic [1:0]       prev_sel;
  logic [8:0]       lo9, hi9, st9, cur9, sum9, dif9;

  dac_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (sclk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (tick && en) state_n = ST_CALC;
      ST_CALC: state_n = ST_TRIG;
      ST_TRIG: state_n = ST_WAIT;
      ST_WAIT: if (dac.set_done || timeout) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Next sample in 9 bits so sums and lo+step never wrap silently.
  always_comb begin
    lo9      = {1'b0, amp_lo};
    hi9      = {1'b0, amp_hi};
    st9      = {1'b0, step};
    cur9     = {1'b0, acc};
    if (cur9 < lo9)      cur9 = lo9;
    else if (cur9 > hi9) cur9 = hi9;
    sum9     = cur9 + st9;
    dif9     = cur9 - st9;
    acc_n    = amp_lo;
    dir_dn_n = dir_dn;
    sq_ph_n  = sq_ph;
    if (wave_sel != prev_sel) begin
      dir_dn_n = 1'b0;
      sq_ph_n  = 1'b0;
    end else begin
      case (wave_sel)
        WAVE_DC:  acc_n = amp_lo;
        // sum9 > hi9 also covers a carry into bit 8, since hi9 never exceeds 8'hFF.
        WAVE_SAW: acc_n = (sum9 > hi9) ? amp_lo : sum9[7:0];
        WAVE_TRI: begin
          if (!dir_dn) begin
            if (sum9 >= hi9) begin
              acc_n    = amp_hi;
              dir_dn_n = 1'b1;
            end else acc_n = sum9[7:0];
          end else begin
            // Turn around on arrival at amp_lo so the bottom code is not repeated.
            if (cur9 <= lo9 + st9) begin
              acc_n    = amp_lo;
              dir_dn_n = 1'b0;
            end else acc_n = dif9[7:0];
          end
        end
        WAVE_SQR: begin
          sq_ph_n = ~sq_ph;
          acc_n   = sq_ph_n ? amp_hi : amp_lo;
        end
        default:  acc_n = amp_lo;
      endcase
    end
    if (amp_lo >= amp_hi) acc_n = amp_lo;
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      dir_dn   <= 1'b0;
      sq_ph    <= 1'b0;
      prev_sel <= WAVE_DC;
      overrun  <= 1'b0;
    end else begin
      if (state == ST_CALC) begin
        acc      <= acc_n;
        dir_dn   <= dir_dn_n;
        sq_ph    <= sq_ph_n;
        prev_sel <= wave_sel;
      end
      if (tick && (state == ST_TRIG || state == ST_WAIT)) overrun <= 1'b1;
    end
  end

`ifdef DAC_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state != ST_WAIT) wd_cnt <= '0;
      else                  wd_cnt <= wd_cnt + 1'b1;
      if (timeout) err <= 1'b1;
    end
  end

  assign timeout = (state == ST_WAIT) && !dac.set_done && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign dac.vol      = acc;
  assign dac.set_trig = (state == ST_TRIG);
  assign busy         = (state == ST_TRIG) || (state == ST_WAIT);
  assign state_dbg    = state;
endmodule
